sc_stream_counter: RTL
======================

Name: sc_stream_counter

Overview:
Stochastic-to-binary back end of the SC datapath. It consumes the single-bit product stream from the SNG/AND stage (`output_circuit`) over a fixed window of accepted samples and counts the ones. It returns the count as a binary result using a start/done handshake. While a window is running it drives `sc_en` to gate the upstream LFSR/SNG stage.

Parameters:
- STREAM_LEN, 255, number of accepted samples per window; must satisfy 1 ≤ STREAM_LEN ≤ 2^CNT_W−1.
- CNT_W, 8, width of the ones counter and the sample counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a window; sampled only in IDLE.
- abort  input  1  cancel a running window.
- sc_bit  input  1  stochastic bit from the upstream stage.
- sc_bit_valid  input  1  sc_bit is a real sample this cycle.
- sc_en  output  1  upstream advance enable, equal to busy.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when a window completes.
- result  output  CNT_W+1  converted value.
- result_valid  output  1  result holds a completed window.

Behaviour:
- Reset: asynchronous, active-low. While rst_n=0, and immediately on assertion, all of the following are 0 and state=IDLE: busy, sc_en, done, result, result_valid, ones counter, sample counter.
- State IDLE:
  - start=1 → RUN next cycle.
  - On that edge, ones counter and sample counter clear and result_valid drops to 0.
- State RUN: busy=sc_en=1.
  - Each cycle with sc_bit_valid=1: sample counter +1, and ones counter +sc_bit.
  - Cycles with sc_bit_valid=0 change nothing.
  - When the accepted sample is number STREAM_LEN (sample counter == STREAM_LEN−1 with valid=1), go to DONE next cycle. On that same edge, result is loaded with the final count, including that last sample.
- State DONE: lasts exactly one cycle.
  - done=1, result_valid=1, busy=0.
  - Then → IDLE.
  - result and result_valid hold until the next accepted start or reset.
- abort:
  - In RUN: → IDLE next cycle, no done pulse, counters frozen, result unchanged. result_valid stays 0 because it was cleared at start.
  - abort in IDLE or DONE is ignored.
  - abort and start together in IDLE: start wins, abort is ignored.
- start is ignored in RUN and DONE. A start held high through DONE is accepted in the following IDLE cycle.
- Latency, continuous valid: start sampled at edge 0 → RUN from cycle 1. Samples are accepted on cycles 1..STREAM_LEN. done is high during cycle STREAM_LEN+1.
- Arithmetic:
  - Counters are unsigned CNT_W bits and never wrap, given the STREAM_LEN bound.
  - result is the ones count zero-extended to CNT_W+1 bits.
- sc_bit is don't-care when sc_bit_valid=0; X on sc_bit in that case must not propagate.

Optional Feature:
- Macro: SC_STREAM_BIPOLAR_EN.
- Defined: result = 2·count − STREAM_LEN, as a CNT_W+1-bit two's-complement value (bipolar SC decoding). The computation is registered on the same edge as the unipolar load, so latency is unchanged.
- Undefined: unipolar count as above, with no subtractor logic.

Test Plan:
1. STREAM_LEN=255, sc_bit=1, sc_bit_valid=1, start pulse → busy for 255 cycles, done exactly at cycle 256, result=9'd255, result_valid=1 held afterwards.
2. sc_bit alternating 1,0,… starting with 1, valid=1 → result=9'd128. A second start then clears result_valid on the first RUN cycle.
3. sc_bit=1, sc_bit_valid toggling 1,0,… → done at cycle 510, result=255. Invalid cycles add nothing even with sc_bit=1.
4. abort after 100 samples → no done pulse, busy/sc_en low next cycle, result_valid=0. A subsequent start runs a full window correctly.
5. rst_n asserted mid-RUN, asynchronously, between clock edges → all outputs 0 before the next edge. After release, the block stays in IDLE until start.
6. SC_STREAM_BIPOLAR_EN defined: all-zero stream → result=9'h101 (−255); 128 ones → 9'h001; 255 ones → 9'h0FF.

Source files
------------

// File: rtl/sc_stream_counter.sv
// Stochastic-to-binary converter: counts ones over a window of STREAM_LEN accepted samples.
// Define SC_STREAM_BIPOLAR_EN to report 2*count - STREAM_LEN instead of the raw count.
module sc_stream_counter #(
  parameter int STREAM_LEN = 255,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             sc_bit,
  input  logic             sc_bit_valid,
  output logic             sc_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W:0]   result,
  output logic             result_valid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(STREAM_LEN - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] ones_q, ones_d;
  logic [CNT_W-1:0] samp_q, samp_d;
  logic [CNT_W:0]   result_q, result_d;
  logic             rv_q, rv_d;

  logic [CNT_W-1:0] ones_inc;
  logic [CNT_W:0]   load_val;

  // ones_inc is only consumed on valid cycles, so an X on sc_bit otherwise never lands in state.
  assign ones_inc = ones_q + CNT_W'(sc_bit);

`ifdef SC_STREAM_BIPOLAR_EN
  localparam logic [CNT_W:0] LEN_EXT = (CNT_W+1)'(STREAM_LEN);
  assign load_val = {ones_inc, 1'b0} - LEN_EXT;
`else
  assign load_val = {1'b0, ones_inc};
`endif

  always_comb begin
    state_d  = state_q;
    ones_d   = ones_q;
    samp_d   = samp_q;
    result_d = result_q;
    rv_d     = rv_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          ones_d  = '0;
          samp_d  = '0;
          rv_d    = 1'b0;
        end
      end
      S_RUN: begin
        // Abort takes priority over a sample arriving in the same cycle.
        if (abort) begin
          state_d = S_IDLE;
        end else if (sc_bit_valid) begin
          ones_d = ones_inc;
          samp_d = samp_q + 1'b1;
          if (samp_q == LAST_IDX) begin
            state_d  = S_DONE;
            result_d = load_val;
            rv_d     = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ones_q   <= '0;
      samp_q   <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ones_q   <= ones_d;
      samp_q   <= samp_d;
      result_q <= result_d;
      rv_q     <= rv_d;
    end
  end

  assign busy         = (state_q == S_RUN);
  assign sc_en        = busy;
  assign done         = (state_q == S_DONE);
  assign result       = result_q;
  assign result_valid = rv_q;

endmodule
